// File: rtl/seven_seg_scan_n.sv
// Time-multiplexed common-anode 7-segment scanner: per-digit glyph lanes,
// frame-boundary snapshots, leading-zero blanking and 16-level PWM dimming.

module seven_seg_lane #(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  // Active-low {g,f,e,d,c,b,a}; non-decimal codes stay dark unless hex is enabled
  always_comb begin
    glyph = 7'b1111111;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: if (HEX_MODE != 0) glyph = 7'b0001000;
      4'hB: if (HEX_MODE != 0) glyph = 7'b0000011;
      4'hC: if (HEX_MODE != 0) glyph = 7'b1000110;
      4'hD: if (HEX_MODE != 0) glyph = 7'b0100001;
      4'hE: if (HEX_MODE != 0) glyph = 7'b0000110;
      4'hF: if (HEX_MODE != 0) glyph = 7'b0001110;
      default: ;
    endcase
  end
endmodule

module seven_seg_scan_n #(
  parameter int NUM_DIGITS      = 4,
  parameter int DISPLAY_REFRESH = 27000,
  parameter int HEX_MODE        = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lzb_en_i,
  input  logic [3:0]              bright_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [6:0]              cathode_o,
  output logic                    dp_o,
  output logic                    frame_o
);
  localparam int CW = $clog2(DISPLAY_REFRESH);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] DWELL_MAX = CW'(DISPLAY_REFRESH - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]                 dwell_cnt;
  logic [IW-1:0]                 idx;
  logic [3:0]                    pwm;
  logic [NUM_DIGITS-1:0][3:0]    snap_data;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic                          snap_lzb;
  logic                          adv, wrap;

  logic [NUM_DIGITS-1:0][6:0]    glyph;
  logic [NUM_DIGITS-1:0]         blank;
  logic                          zero_run;
  logic                          lit;
  logic [NUM_DIGITS-1:0]         anode_nxt;
  logic [6:0]                    cathode_nxt;
  logic                          dp_nxt;

  assign adv  = (dwell_cnt == '0);
  assign wrap = adv && (idx == IDX_MAX);

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_lane
      seven_seg_lane #(.HEX_MODE(HEX_MODE)) u_lane (
        .nib   (snap_data[k]),
        .glyph (glyph[k])
      );
    end
  endgenerate

  // A digit blanks only when it and every more-significant nibble is zero
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      zero_run = zero_run && (snap_data[d] == 4'h0);
      blank[d] = snap_lzb && zero_run;
    end
  end

  always_comb begin
    lit         = (pwm <= bright_i);
    anode_nxt   = '1;
    cathode_nxt = 7'b1111111;
    dp_nxt      = 1'b1;
    if (lit && !blank[idx]) begin
      anode_nxt[idx] = 1'b0;
      cathode_nxt    = glyph[idx];
      dp_nxt         = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_cnt <= DWELL_MAX;
      idx       <= '0;
      pwm       <= 4'd0;
      snap_data <= '0;
      snap_dp   <= '0;
      snap_lzb  <= 1'b0;
      anode_o   <= '1;
      cathode_o <= 7'b1111111;
      dp_o      <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      pwm       <= pwm + 4'd1;
      dwell_cnt <= adv ? DWELL_MAX : dwell_cnt - CW'(1);
      if (adv) idx <= wrap ? '0 : idx + IW'(1);
      // Inputs are only sampled at the frame boundary so a frame never tears
      if (wrap) begin
        snap_data <= data_i;
        snap_dp   <= dp_i;
        snap_lzb  <= lzb_en_i;
      end
      frame_o   <= wrap;
      anode_o   <= anode_nxt;
      cathode_o <= cathode_nxt;
      dp_o      <= dp_nxt;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n: two instances (hex and decimal-only)
// share stimulus; every 4-cycle digit dwell is checked against fixed values.

module tb_seven_seg_scan_n;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         GA = 7'b0001000, GD = 7'b0100001, GE = 7'b0000110,
                         GF = 7'b0001110, OFF = 7'b1111111;
  localparam logic [3:0] ALL = 4'hF, NONE = 4'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic        lzb_en_i;
  logic [3:0]  bright_i;
  logic [3:0]  anode_o, anode2;
  logic [6:0]  cathode_o, cathode2;
  logic        dp_o, dp2, frame_o, frame2;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  seven_seg_scan_n #(.NUM_DIGITS(4), .DISPLAY_REFRESH(4), .HEX_MODE(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .dp_i(dp_i),
    .lzb_en_i(lzb_en_i), .bright_i(bright_i), .anode_o(anode_o),
    .cathode_o(cathode_o), .dp_o(dp_o), .frame_o(frame_o));

  seven_seg_scan_n #(.NUM_DIGITS(4), .DISPLAY_REFRESH(4), .HEX_MODE(0)) u_dut_dec (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .dp_i(dp_i),
    .lzb_en_i(lzb_en_i), .bright_i(bright_i), .anode_o(anode2),
    .cathode_o(cathode2), .dp_o(dp2), .frame_o(frame2));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an, input logic [6:0] ca,
                     input logic [6:0] ca2, input logic dp, input logic fr);
    tests++;
    assert ({anode_o, cathode_o, dp_o, frame_o} === {an, ca, dp, fr}) else begin
      fails++;
      $error("FAIL %s hex: got an=%b ca=%b dp=%b fr=%b, want an=%b ca=%b dp=%b fr=%b",
             tag, anode_o, cathode_o, dp_o, frame_o, an, ca, dp, fr);
    end
    tests++;
    assert ({anode2, cathode2, dp2, frame2} === {an, ca2, dp, fr}) else begin
      fails++;
      $error("FAIL %s dec: got an=%b ca=%b dp=%b fr=%b, want an=%b ca=%b dp=%b fr=%b",
             tag, anode2, cathode2, dp2, frame2, an, ca2, dp, fr);
    end
  endtask

  // One digit dwell; lit[c] says whether cycle c of the dwell is lit
  task automatic check_digit(input string tag, input int d, input logic [3:0] lit,
                             input logic [6:0] ca, input logic [6:0] ca2, input logic dp);
    logic [3:0] oh;
    logic       fr;
    oh = 4'b0001 << d;
    for (int c = 0; c < 4; c++) begin
      tick();
      fr = (d == 3) && (c == 3);
      if (lit[c]) chk($sformatf("%s d%0d c%0d", tag, d, c), ~oh, ca, ca2, dp, fr);
      else        chk($sformatf("%s d%0d c%0d", tag, d, c), 4'hF, OFF, OFF, 1'b1, fr);
    end
  endtask

  initial begin
    rst_i = 1'b1; data_i = 16'h1234; dp_i = 4'b0100; lzb_en_i = 1'b0; bright_i = 4'd15;
    tick(); chk("reset0", 4'hF, OFF, OFF, 1'b1, 1'b0);
    tick(); chk("reset1", 4'hF, OFF, OFF, 1'b1, 1'b0);
    rst_i = 1'b0;

    // First frame shows the zero snapshot
    check_digit("f1", 0, ALL, G0, G0, 1'b1);
    check_digit("f1", 1, ALL, G0, G0, 1'b1);
    check_digit("f1", 2, ALL, G0, G0, 1'b1);
    check_digit("f1", 3, ALL, G0, G0, 1'b1);

    // 1234 with dp on digit 2; data changes while idx=1 stay hidden
    check_digit("f2", 0, ALL, G4, G4, 1'b1);
    data_i = 16'h5678;
    check_digit("f2", 1, ALL, G3, G3, 1'b1);
    check_digit("f2", 2, ALL, G2, G2, 1'b0);
    check_digit("f2", 3, ALL, G1, G1, 1'b1);

    check_digit("f3", 0, ALL, G8, G8, 1'b1);
    check_digit("f3", 1, ALL, G7, G7, 1'b1);
    data_i = 16'h0050; lzb_en_i = 1'b1;
    check_digit("f3", 2, ALL, G6, G6, 1'b0);
    check_digit("f3", 3, ALL, G5, G5, 1'b1);

    // Leading-zero blanking of 0050; digit 2 dp request suppressed
    check_digit("lzb", 0, ALL, G0, G0, 1'b1);
    check_digit("lzb", 1, ALL, G5, G5, 1'b1);
    data_i = 16'h0000;
    check_digit("lzb", 2, NONE, OFF, OFF, 1'b1);
    check_digit("lzb", 3, NONE, OFF, OFF, 1'b1);

    check_digit("lzb0", 0, ALL, G0, G0, 1'b1);
    data_i = 16'hFEDA; dp_i = 4'b0001; lzb_en_i = 1'b0;
    check_digit("lzb0", 1, NONE, OFF, OFF, 1'b1);
    check_digit("lzb0", 2, NONE, OFF, OFF, 1'b1);
    check_digit("lzb0", 3, NONE, OFF, OFF, 1'b1);

    // Hex digits: decimal-only instance keeps anode/dp but dark segments
    check_digit("hex", 0, ALL, GA, OFF, 1'b0);
    check_digit("hex", 1, ALL, GD, OFF, 1'b1);
    data_i = 16'h8888; dp_i = 4'b0000;
    check_digit("hex", 2, ALL, GE, OFF, 1'b1);
    check_digit("hex", 3, ALL, GF, OFF, 1'b1);
    bright_i = 4'd3;

    // PWM: dwell aligned with pwm, so digit d sees pwm 4d..4d+3
    check_digit("b3", 0, ALL, G8, G8, 1'b1);
    check_digit("b3", 1, NONE, OFF, OFF, 1'b1);
    check_digit("b3", 2, NONE, OFF, OFF, 1'b1);
    check_digit("b3", 3, NONE, OFF, OFF, 1'b1);
    bright_i = 4'd5;
    check_digit("b5", 0, ALL, G8, G8, 1'b1);
    check_digit("b5", 1, 4'b0011, G8, G8, 1'b1);
    check_digit("b5", 2, NONE, OFF, OFF, 1'b1);
    check_digit("b5", 3, NONE, OFF, OFF, 1'b1);
    bright_i = 4'd0;
    check_digit("b0", 0, 4'b0001, G8, G8, 1'b1);
    check_digit("b0", 1, NONE, OFF, OFF, 1'b1);
    check_digit("b0", 2, NONE, OFF, OFF, 1'b1);
    check_digit("b0", 3, NONE, OFF, OFF, 1'b1);
    bright_i = 4'd15;

    // Reset mid-dwell with idx=2, then restart from digit 0 with zero snapshot
    check_digit("f10", 0, ALL, G8, G8, 1'b1);
    check_digit("f10", 1, ALL, G8, G8, 1'b1);
    tick();
    rst_i = 1'b1;
    tick(); chk("rst_mid0", 4'hF, OFF, OFF, 1'b1, 1'b0);
    tick(); chk("rst_mid1", 4'hF, OFF, OFF, 1'b1, 1'b0);
    rst_i = 1'b0;
    check_digit("post", 0, ALL, G0, G0, 1'b1);
    check_digit("post", 1, ALL, G0, G0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
